// File: rtl/pulse_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
package pulse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_e;

   // Width of the shared period counter: must hold max(high, gap) - 1 loads.
   function automatic int cnt_width(input int high_cycles, input int gap_cycles);
      int m;
      m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pulse_stretcher.sv
// Stretches each accepted request into a HIGH_CYCLES pulse followed by a GAP_CYCLES
// low guard, queuing requests that arrive while a period is in progress.
module pulse_stretcher
   import pulse_pkg::*;
#(
   parameter int HIGH_CYCLES = 4,
   parameter int GAP_CYCLES  = 2,
   parameter int QUEUE_DEPTH = 3
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               in,
   input  logic                               clear_ovf,
   output logic                               out,
   output logic                               busy,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending,
   output logic                               overflow
);

   localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
   localparam int PW = $clog2(QUEUE_DEPTH + 1);
   localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [PW-1:0] PEND_MAX  = PW'(QUEUE_DEPTH);
   localparam logic [PW-1:0] PEND_ONE  = PW'(1);

   if (HIGH_CYCLES < 1) begin : g_bad_high
      $error("pulse_stretcher: HIGH_CYCLES must be >= 1");
   end
   if (GAP_CYCLES < 0) begin : g_bad_gap
      $error("pulse_stretcher: GAP_CYCLES must be >= 0");
   end
   if (QUEUE_DEPTH < 1) begin : g_bad_depth
      $error("pulse_stretcher: QUEUE_DEPTH must be >= 1");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   pending_q, pending_d;
   logic            ovf_q, ovf_d;
   logic            out_q, busy_q;
   logic            final_s, restart_s, drop_s;

   // Next-state, counter, queue and overflow evaluation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      drop_s    = 1'b0;

      final_s   = (cnt_q == '0) &&
                  ((state_q == ST_GAP) || ((state_q == ST_HIGH) && (GAP_CYCLES == 0)));
      restart_s = final_s && ((pending_q != '0) || in);

      case (state_q)
         ST_IDLE: begin
            if (in) begin
               state_d = ST_HIGH;
               cnt_d   = HIGH_LOAD;
            end else begin
               cnt_d   = '0;
            end
         end
         ST_HIGH, ST_GAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else if ((state_q == ST_HIGH) && (GAP_CYCLES > 0)) begin
               state_d = ST_GAP;
               cnt_d   = GAP_LOAD;
            end else if (restart_s) begin
               state_d = ST_HIGH;
               cnt_d   = HIGH_LOAD;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // On the final cycle a live request is consumed directly, so only a
      // queued entry with no new request shrinks the queue.
      if ((state_q != ST_IDLE) && in && !final_s) begin
         if (pending_q < PEND_MAX) begin
            pending_d = pending_q + PEND_ONE;
         end else begin
            drop_s = 1'b1;
         end
      end else if (final_s && (pending_q != '0) && !in) begin
         pending_d = pending_q - PEND_ONE;
      end else begin
         pending_d = pending_q;
      end

      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (clear_ovf) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // State and registered outputs, all derived from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
         out_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         out_q     <= (state_d == ST_HIGH);
         busy_q    <= (state_d != ST_IDLE);
      end
   end

   assign out      = out_q;
   assign busy     = busy_q;
   assign pending  = pending_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default parameters plus a GAP_CYCLES=0 instance.
module tb_pulse_stretcher;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_s;
   logic       clear_ovf;
   logic       out, busy, overflow;
   logic [1:0] pending;
   logic       out2, busy2, overflow2;
   logic [1:0] pending2;

   int checks = 0;
   int errors = 0;
   int cur    = 0;
   int rises  = 0;
   logic prev_out;

   always #5 clk = ~clk;

   pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .QUEUE_DEPTH(3)) dut (
      .clk(clk), .reset(reset), .in(in_s), .clear_ovf(clear_ovf),
      .out(out), .busy(busy), .pending(pending), .overflow(overflow)
   );

   pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .QUEUE_DEPTH(3)) dut_nogap (
      .clk(clk), .reset(reset), .in(in_s), .clear_ovf(clear_ovf),
      .out(out2), .busy(busy2), .pending(pending2), .overflow(overflow2)
   );

   task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: got %0d, expected %0d", tag, c, obs, exp);
      end
   endtask

   // Cycle c is the interval after edge c-1; inputs set in cycle c are sampled at edge c.
   task automatic step();
      @(posedge clk);
      #1;
      cur++;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_s      = 1'b0;
      clear_ovf = 1'b0;
      step();
      step();
      reset = 1'b0;
      cur   = 1;
   endtask

   initial begin
      reset = 1'b1; in_s = 1'b0; clear_ovf = 1'b0;

      // Single request at cycle 10
      do_reset();
      chk("rst_out", cur, out, 0);
      chk("rst_busy", cur, busy, 0);
      chk("rst_pending", cur, pending, 0);
      chk("rst_ovf", cur, overflow, 0);
      while (cur <= 18) begin
         in_s = (cur == 10);
         chk("single_out", cur, out, (cur >= 11 && cur <= 14));
         chk("single_busy", cur, busy, (cur >= 11 && cur <= 16));
         chk("single_pending", cur, pending, 0);
         step();
      end

      // Three back-to-back requests
      do_reset();
      while (cur <= 30) begin
         in_s = (cur >= 10 && cur <= 12);
         chk("burst_out", cur, out, (cur >= 11 && cur <= 26 && ((cur - 11) % 6) < 4));
         chk("burst_pending", cur, pending,
             (cur <= 11) ? 0 : (cur == 12) ? 1 : (cur <= 16) ? 2 : (cur <= 22) ? 1 : 0);
         chk("burst_ovf", cur, overflow, 0);
         step();
      end

      // Held request saturates queue, overflow, then clear
      do_reset();
      rises = 0;
      prev_out = 1'b0;
      while (cur <= 45) begin
         in_s      = (cur >= 10 && cur <= 15);
         clear_ovf = (cur == 40);
         if (out && !prev_out) rises++;
         prev_out = out;
         chk("sat_out", cur, out, (cur >= 11 && cur <= 32 && ((cur - 11) % 6) < 4));
         chk("sat_pending", cur, pending,
             (cur <= 11) ? 0 : (cur == 12) ? 1 : (cur == 13) ? 2 : (cur <= 16) ? 3 :
             (cur <= 22) ? 2 : (cur <= 28) ? 1 : 0);
         chk("sat_ovf", cur, overflow, (cur >= 15 && cur <= 40));
         step();
      end
      chk("sat_pulse_count", cur, rises, 4);

      // Reset aborts HIGH with two queued requests; in during reset ignored
      do_reset();
      while (cur <= 25) begin
         in_s  = (cur >= 9 && cur <= 12);
         reset = (cur == 12);
         if (cur == 12) begin
            chk("abort_pre_out", cur, out, 1);
            chk("abort_pre_pending", cur, pending, 2);
         end else if (cur >= 13) begin
            chk("abort_out", cur, out, 0);
            chk("abort_busy", cur, busy, 0);
            chk("abort_pending", cur, pending, 0);
         end
         step();
      end
      reset = 1'b0;

      // Request on final GAP cycle with one queued, then drop coinciding with clear
      do_reset();
      while (cur <= 31) begin
         in_s      = (cur == 10) || (cur == 11) || (cur == 16) || (cur >= 24 && cur <= 27);
         clear_ovf = (cur == 27) || (cur == 29);
         if (cur == 16) chk("restart_pending_before", cur, pending, 1);
         if (cur == 17) begin
            chk("restart_out", cur, out, 1);
            chk("restart_pending", cur, pending, 1);
         end
         if (cur == 23) chk("restart_drain", cur, pending, 0);
         if (cur == 27) begin
            chk("drop_pre_pending", cur, pending, 3);
            chk("drop_pre_ovf", cur, overflow, 0);
         end
         if (cur == 28) chk("set_beats_clear", cur, overflow, 1);
         if (cur == 29) chk("ovf_sticky", cur, overflow, 1);
         if (cur == 30) chk("ovf_cleared", cur, overflow, 0);
         step();
      end

      // GAP_CYCLES=0: restart yields a continuous high
      do_reset();
      while (cur <= 21) begin
         in_s = (cur == 10) || (cur == 11);
         chk("nogap_out", cur, out2, (cur >= 11 && cur <= 18));
         chk("nogap_busy", cur, busy2, (cur >= 11 && cur <= 18));
         chk("nogap_pending", cur, pending2, (cur >= 12 && cur <= 14));
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
